// File: rtl/keycode_event_ctrl.sv
// Avalon-MM keycode event controller: register-written keycodes are queued in a
// small FIFO and handed to game logic through a valid/ready port.
module keycode_event_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  key_code,
    output logic        key_valid,
    input  logic        key_ready,
    output logic [7:0]  out_port,
    output logic        irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic irq_en;
        logic norepeat;
        logic enable;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{irq_en: 1'b0, norepeat: 1'b0, enable: 1'b1};

    ctrl_t          ctrl;
    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [CW-1:0]  count;
    logic           overflow;

    logic       bus_write;
    logic [7:0] code;
    logic       empty;
    logic       full;
    logic       pop;
    logic       push_req;
    logic       push;
    logic       drop;
    logic       flush;
    logic       ovf_clr;

    assign bus_write = chipselect && !write_n;
    assign code      = writedata[7:0];
    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));

    assign key_valid = ctrl.enable && !empty;
    assign key_code  = empty ? 8'h00 : mem[rd_ptr];
    assign pop       = key_valid && key_ready;
    assign irq       = overflow && ctrl.irq_en;

    // Repeat suppression compares against out_port before this write updates it.
    assign push_req = bus_write && (address == 2'd0) && (code != 8'h00)
                      && !(ctrl.norepeat && (code == out_port));
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;
    assign flush    = bus_write && (address == 2'd1) && writedata[0];
    assign ovf_clr  = bus_write && (address == 2'd1) && writedata[8];

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata = {24'b0, out_port};
            2'd1: readdata = {23'b0, overflow, 6'(count), full, empty};
            2'd2: readdata = {29'b0, ctrl};
            default: readdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_port <= 8'h00;
            ctrl     <= CTRL_RESET;
            overflow <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (bus_write && (address == 2'd0))
                out_port <= code;
            if (bus_write && (address == 2'd2))
                ctrl <= ctrl_t'(writedata[2:0]);
            if (drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
            // Flush and push never coincide (different addresses); flush beats pop.
            if (flush) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)
                    count <= count + 1'b1;
                else if (pop && !push)
                    count <= count - 1'b1;
            end
        end
    end

    // NOTE: storage is not reset; count and pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= code;
    end

    logic unused_writedata;
    assign unused_writedata = &{1'b0, writedata[31:9]};

endmodule

// File: doc/keycode_event_ctrl.md
KEYCODE_EVENT_CTRL -- requirements
Module: keycode_event_ctrl

Interface
REQ-001 Parameter: DEPTH, 4, FIFO depth in entries; power of two, 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 address  input  2  Avalon-MM register select.
REQ-005 chipselect  input  1  Avalon-MM slave select.
REQ-006 write_n  input  1  Avalon-MM write strobe, active-low.
REQ-007 writedata  input  32  Avalon-MM write data.
REQ-008 readdata  output  32  Avalon-MM read data, combinational from address, zero-wait.
REQ-009 key_code  output  8  FIFO head keycode to game logic.
REQ-010 key_valid  output  1  key_code holds a valid event.
REQ-011 key_ready  input  1  game logic accepts the event.
REQ-012 out_port  output  8  last keycode written to address 0, including 0x00.
REQ-013 irq  output  1  level interrupt: overflow flag AND irq_en.

Function
REQ-014 Bus write = chipselect && !write_n; reads have no side effects.
REQ-015 Addr 0 write: out_port <= writedata[7:0] unconditionally; enqueue writedata[7:0] only if nonzero and not suppressed.
REQ-016 Suppression: ctrl.norepeat=1 and writedata[7:0] equals the current out_port -> no enqueue, no overflow.
REQ-017 Enqueue when full and no pop this cycle -> code dropped, overflow flag set; FIFO contents unchanged.
REQ-018 Enqueue when full with pop the same cycle -> accepted; count unchanged.
REQ-019 Pop occurs when key_valid && key_ready; head advances next cycle.
REQ-020 key_valid = ctrl.enable && count!=0; key_code = head entry (0x00 when empty).
REQ-021 No bypass: a code pushed into an empty FIFO asserts key_valid the cycle after the write.
REQ-022 Pointers wrap modulo DEPTH; count ranges 0..DEPTH; count and pointers never exceed bounds.
REQ-023 Addr 0 read: {24'b0, out_port}.
REQ-024 Addr 1 read (status): [0] empty, [1] full, [7:2] count, [8] overflow, others 0.
REQ-025 Addr 1 write: bit0=1 flushes FIFO (count, pointers -> 0); bit8=1 clears overflow; other bits ignored.
REQ-026 Flush and pop in the same cycle: flush wins; count=0 next cycle.
REQ-027 Overflow set and clear in the same cycle cannot occur (single bus port); an overflow event in any cycle sets the flag.
REQ-028 Addr 2 read/write (ctrl): [0] enable, [1] norepeat, [2] irq_en; others read 0.
REQ-029 ctrl.enable=0 holds events in the FIFO (key_valid=0, no pops); enqueue continues.
REQ-030 Addr 3 reads 0; writes ignored.

Reset
REQ-031 On reset: out_port=0x00, count=0, pointers=0, overflow=0, ctrl=0x1 (enable=1, norepeat=0, irq_en=0).
REQ-032 Reset mid-operation discards all queued events; key_valid=0 the first cycle after reset.
REQ-033 Reset takes priority over any concurrent bus write or pop.

Verification
REQ-034 Write 0x1C, 0x00, 0x1A to addr 0, key_ready=0 -> out_port ends 0x1A; status count=2; key_code=0x1C, key_valid=1.
REQ-035 With norepeat=1, write 0x04 twice -> count=1; with norepeat=0 -> count=2.
REQ-036 DEPTH=4, key_ready=0, write 5 nonzero codes -> full=1, overflow=1, 5th code dropped; with irq_en=1, irq=1; write 0x100 to addr 1 -> overflow=0, irq=0.
REQ-037 FIFO full, key_ready=1 in the cycle of a 5th write -> accepted, count stays 4, codes pop in write order.
REQ-038 Queue 3 codes, enable=0 -> key_valid=0 with key_ready=1 held, count=3; enable=1 -> 3 pops on consecutive cycles.
REQ-039 Queue 2 codes, assert reset one cycle -> count=0, out_port=0x00, ctrl reads 0x1.
